// File: rtl/fp64_atan2_cordic.sv
// rtl/fp64_atan2_cordic.sv - iterative fp64 atan2 using CORDIC vectoring, one micro-rotation per clock
// Optional build macro FP_ATAN2_RNE_EN: round-to-nearest-even in NORM (default truncates).
module fp64_atan2_cordic #(
  parameter int ITERS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] y_in,
  input  logic [63:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, NORM, DONE} state_t;
  state_t state, state_next;

  localparam logic [62:0] PI_M   = 63'h400921FB54442D18;
  localparam logic [62:0] PI2_M  = 63'h3FF921FB54442D18;
  localparam logic [62:0] PI4_M  = 63'h3FE921FB54442D18;
  localparam logic [62:0] PI34_M = 63'h4002D97C7F3321D2;
  localparam logic signed [63:0] PI_Q59 = 64'sh1921FB54442D1847;

  // atan(2^-i) in Q3.59; entry 0 is pi/4, the rest come from the Taylor series at 124 fraction bits.
  function automatic logic [62*64-1:0] atan_rom_init();
    logic [127:0]      acc;
    logic [127:0]      term;
    logic [62*64-1:0]  rom;
    rom = '0;
    rom[63:0] = 64'h06487ED5110B4612;
    for (int i = 1; i < 62; i++) begin
      acc = '0;
      for (int k = 1; i * k <= 124; k += 2) begin
        term = (128'd1 << (124 - i * k)) / 128'(k);
        if ((((k - 1) / 2) % 2) == 0) acc = acc + term;
        else                          acc = acc - term;
      end
      rom[i*64 +: 64] = 64'((acc + (128'd1 << 64)) >> 65);
    end
    return rom;
  endfunction

  localparam logic [62*64-1:0] ATAN_ROM = atan_rom_init();

  logic [63:0]        xa, ya;
  logic signed [63:0] xr, yr, zr;
  logic [5:0]         it;

  logic        sx, sy;
  logic [10:0] ex, ey;
  logic [51:0] fx, fy;
  logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;

  assign {sx, ex, fx} = xa;
  assign {sy, ey, fy} = ya;
  assign x_nan  = (ex == 11'h7FF) && (fx != 52'd0);
  assign y_nan  = (ey == 11'h7FF) && (fy != 52'd0);
  assign x_inf  = (ex == 11'h7FF) && (fx == 52'd0);
  assign y_inf  = (ey == 11'h7FF) && (fy == 52'd0);
  assign x_zero = (ex == 11'd0) && (fx == 52'd0);
  assign y_zero = (ey == 11'd0) && (fy == 52'd0);

  logic        special, spec_inv, spec_inex;
  logic [63:0] spec_res;

  always_comb begin
    special   = 1'b1;
    spec_res  = 64'd0;
    spec_inv  = 1'b0;
    spec_inex = 1'b1;
    if (x_nan || y_nan) begin
      spec_inex = 1'b0;
      if (y_nan) begin
        spec_res = ya | 64'h0008_0000_0000_0000;
        spec_inv = ~fy[51];
      end else begin
        spec_res = xa | 64'h0008_0000_0000_0000;
        spec_inv = ~fx[51];
      end
    end else if (y_zero) begin
      if (!sx) begin
        spec_res  = ya;
        spec_inex = 1'b0;
      end else begin
        spec_res = {sy, PI_M};
      end
    end else if (y_inf) begin
      if (x_inf) spec_res = sx ? {sy, PI34_M} : {sy, PI4_M};
      else       spec_res = {sy, PI2_M};
    end else if (x_zero) begin
      spec_res = {sy, PI2_M};
    end else if (x_inf) begin
      if (!sx) begin
        spec_res  = {sy, 63'd0};
        spec_inex = 1'b0;
      end else begin
        spec_res = {sy, PI_M};
      end
    end else begin
      special = 1'b0;
    end
  end

  logic [10:0]        ex_e, ey_e, diff;
  logic [63:0]        mx, my, mx_al, my_al;
  logic signed [63:0] x0, y0, z0;

  always_comb begin
    ex_e  = (ex == 11'd0) ? 11'd1 : ex;
    ey_e  = (ey == 11'd0) ? 11'd1 : ey;
    mx    = {3'b000, (ex != 11'd0), fx, 8'd0};
    my    = {3'b000, (ey != 11'd0), fy, 8'd0};
    mx_al = mx;
    my_al = my;
    diff  = 11'd0;
    if (ey_e > ex_e) begin
      diff  = ey_e - ex_e;
      mx_al = (diff >= 11'd62) ? 64'd0 : (mx >> diff);
    end else begin
      diff  = ex_e - ey_e;
      my_al = (diff >= 11'd62) ? 64'd0 : (my >> diff);
    end
    // Negative x is folded into the right half-plane: x stays the magnitude, y flips, z gets +/-pi.
    x0 = $signed(mx_al);
    y0 = (sx ^ sy) ? -$signed(my_al) : $signed(my_al);
    if (sx) z0 = sy ? -PI_Q59 : PI_Q59;
    else    z0 = 64'sd0;
  end

  logic signed [63:0] sh_x, sh_y, rom_val, x_n, y_n, z_n;

  always_comb begin
    sh_x    = xr >>> it;
    sh_y    = yr >>> it;
    rom_val = $signed(ATAN_ROM[{it, 6'd0} +: 64]);
    if (yr < 0) begin
      x_n = xr - sh_y;
      y_n = yr + sh_x;
      z_n = zr - rom_val;
    end else begin
      x_n = xr + sh_y;
      y_n = yr - sh_x;
      z_n = zr + rom_val;
    end
  end

  logic [63:0] z_mag;
  logic [5:0]  lead, lsh;
  logic [51:0] frac;
  logic [10:0] zexp;
  logic [62:0] mag_r;
  logic [63:0] norm_res;
`ifdef FP_ATAN2_RNE_EN
  logic [10:0] low;
  logic        guard, sticky;
`endif

  always_comb begin
    z_mag = zr[63] ? 64'(-zr) : 64'(zr);
    lead  = 6'd0;
    for (int b = 0; b < 64; b++) begin
      if (z_mag[b]) lead = 6'(b);
    end
    lsh  = 6'd63 - lead;
    frac = 52'((z_mag << lsh) >> 11);
    zexp = 11'd964 + {5'd0, lead};
`ifdef FP_ATAN2_RNE_EN
    low    = 11'(z_mag << lsh);
    guard  = low[10];
    sticky = |low[9:0];
    mag_r  = {zexp, frac} + {62'd0, guard & (sticky | frac[0])};
`else
    mag_r  = {zexp, frac};
`endif
    norm_res = (z_mag == 64'd0) ? 64'd0 : {zr[63], mag_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = PREP;
      PREP: begin
        busy       = 1'b1;
        state_next = special ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (it == 6'(ITERS - 1)) state_next = NORM;
      end
      NORM: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? PREP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xa      <= 64'd0;
      ya      <= 64'd0;
      xr      <= 64'sd0;
      yr      <= 64'sd0;
      zr      <= 64'sd0;
      it      <= 6'd0;
      result  <= 64'd0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            xa <= x_in;
            ya <= y_in;
          end
        end
        PREP: begin
          if (special) begin
            result  <= spec_res;
            invalid <= spec_inv;
            inexact <= spec_inex;
          end else begin
            xr <= x0;
            yr <= y0;
            zr <= z0;
            it <= 6'd0;
          end
        end
        ITER: begin
          xr <= x_n;
          yr <= y_n;
          zr <= z_n;
          it <= it + 6'd1;
        end
        NORM: begin
          result  <= norm_res;
          invalid <= 1'b0;
          inexact <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp64_atan2_cordic.sv
// tb/tb_fp64_atan2_cordic.sv - directed table-driven bench for fp64_atan2_cordic
module tb_fp64_atan2_cordic;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] y_in, x_in, result;
  logic        busy, done, invalid, inexact;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] M_ONE = 64'hBFF0000000000000;
  localparam logic [63:0] PI4   = 64'h3FE921FB54442D18;
  localparam logic [63:0] PI34  = 64'h4002D97C7F3321D2;

  fp64_atan2_cordic #(.ITERS(60)) dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .x_in(x_in),
    .busy(busy), .done(done), .result(result), .invalid(invalid), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] y;
    logic [63:0] x;
    logic [63:0] res;
    int          tol;
    logic        inv;
    logic        inex;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int tol);
    logic [63:0] d;
    n_checks++;
    if (64'(act[62:0]) >= 64'(exp[62:0])) d = 64'(act[62:0]) - 64'(exp[62:0]);
    else                                  d = 64'(exp[62:0]) - 64'(act[62:0]);
    if ((^act === 1'bx) || (act[63] !== exp[63]) || (d > 64'(tol))) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (tolerance %0d ulp)", name, act, exp, tol);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Leaves the caller at the falling edge one cycle after the sampling edge.
  task automatic start_op(input logic [63:0] y, input logic [63:0] x);
    @(negedge clk);
    y_in  = y;
    x_in  = x;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    start_op(v.y, v.x);
    c = 1;
    check({v.name, "_busy"}, 64'(busy), 64'd1, 0);
    while (c < 200 && done !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    check_int({v.name, "_latency"}, c, v.lat);
    check({v.name, "_result"}, result, v.res, v.tol);
    check({v.name, "_invalid"}, 64'(invalid), 64'(v.inv), 0);
    check({v.name, "_inexact"}, 64'(inexact), 64'(v.inex), 0);
    check({v.name, "_busy_done"}, 64'(busy), 64'd0, 0);
    @(negedge clk);
    check({v.name, "_done_pulse"}, 64'(done), 64'd0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, ndone, first;
    vec_t v;
    rst = 1'b0; start = 1'b0; x_in = 64'd0; y_in = 64'd0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy",    64'(busy),    64'd0, 0);
    check("reset_done",    64'(done),    64'd0, 0);
    check("reset_result",  result,       64'd0, 0);
    check("reset_invalid", 64'(invalid), 64'd0, 0);
    check("reset_inexact", 64'(inexact), 64'd0, 0);
    rst = 1'b0;

    vecs.push_back('{ONE,   ONE,   PI4,                   4, 1'b0, 1'b1, 63, "atan_1_1"});
    vecs.push_back('{M_ONE, M_ONE, 64'hC002D97C7F3321D2, 4, 1'b0, 1'b1, 63, "atan_m1_m1"});
    vecs.push_back('{ONE,   M_ONE, PI34,                  4, 1'b0, 1'b1, 63, "atan_1_m1"});
    vecs.push_back('{M_ONE, ONE,   64'hBFE921FB54442D18, 4, 1'b0, 1'b1, 63, "atan_m1_1"});
    vecs.push_back('{64'h4008000000000000, 64'h4008000000000000, PI4, 4, 1'b0, 1'b1, 63, "atan_3_3"});
    vecs.push_back('{64'h3FE0000000000000, 64'hBFE0000000000000, PI34, 4, 1'b0, 1'b1, 63, "atan_h_mh"});
    vecs.push_back('{ONE,   64'h39B0000000000000, 64'h3FF921FB54442D18, 4, 1'b0, 1'b1, 63, "shift_clamp_pos"});
    vecs.push_back('{ONE,   64'hB9B0000000000000, 64'h3FF921FB54442D18, 4, 1'b0, 1'b1, 63, "shift_clamp_negx"});
    vecs.push_back('{64'hB9B0000000000000, M_ONE, 64'hC00921FB54442D18, 4, 1'b0, 1'b1, 63, "tiny_negy_negx"});
    vecs.push_back('{64'h0000000000000000, M_ONE, 64'h400921FB54442D18, 0, 1'b0, 1'b1, 2, "pz_m1"});
    vecs.push_back('{64'h8000000000000000, ONE,   64'h8000000000000000, 0, 1'b0, 1'b0, 2, "mz_1"});
    vecs.push_back('{64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000, 0, 1'b0, 1'b0, 2, "pz_pz"});
    vecs.push_back('{64'h8000000000000000, 64'hFFF0000000000000, 64'hC00921FB54442D18, 0, 1'b0, 1'b1, 2, "mz_minf"});
    vecs.push_back('{64'h7FF0000000000001, ONE,   64'h7FF8000000000001, 0, 1'b1, 1'b0, 2, "snan_y"});
    vecs.push_back('{ONE,   64'hFFF8000000000123, 64'hFFF8000000000123, 0, 1'b0, 1'b0, 2, "qnan_x"});
    vecs.push_back('{64'h7FF0000000000000, 64'hFFF0000000000000, PI34, 0, 1'b0, 1'b1, 2, "pinf_minf"});
    vecs.push_back('{64'hFFF0000000000000, 64'h7FF0000000000000, 64'hBFE921FB54442D18, 0, 1'b0, 1'b1, 2, "minf_pinf"});
    vecs.push_back('{64'h7FF0000000000000, 64'hC014000000000000, 64'h3FF921FB54442D18, 0, 1'b0, 1'b1, 2, "pinf_m5"});
    vecs.push_back('{ONE,   64'h0000000000000000, 64'h3FF921FB54442D18, 0, 1'b0, 1'b1, 2, "one_pz"});
    vecs.push_back('{M_ONE, 64'h7FF0000000000000, 64'h8000000000000000, 0, 1'b0, 1'b0, 2, "m1_pinf"});
    vecs.push_back('{64'h4000000000000000, 64'hFFF0000000000000, 64'h400921FB54442D18, 0, 1'b0, 1'b1, 2, "two_minf"});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of an iteration run.
    start_op(ONE, ONE);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy",    64'(busy),    64'd0, 0);
    check("midrst_done",    64'(done),    64'd0, 0);
    check("midrst_result",  result,       64'd0, 0);
    check("midrst_invalid", 64'(invalid), 64'd0, 0);
    check("midrst_inexact", 64'(inexact), 64'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    v = '{ONE, ONE, PI4, 4, 1'b0, 1'b1, 63, "after_rst"};
    run_vec(v);

    // A start while busy is ignored; a start during the done cycle is accepted.
    start_op(ONE, ONE);
    c = 1; ndone = 0; first = 0;
    while (c < 63) begin
      @(negedge clk);
      c++;
      if (c == 5) begin
        y_in = M_ONE; x_in = M_ONE; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    check_int("ignore_done_count", ndone, 1);
    check_int("ignore_done_cycle", first, 63);
    check("ignore_result", result, PI4, 4);
    y_in = 64'h7FF0000000000000; x_in = 64'hFFF0000000000000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1, 0);
    @(negedge clk);
    check("b2b_done", 64'(done), 64'd1, 0);
    check("b2b_result", result, PI34, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp64_atan2_cordic.md
Name: fp64_atan2_cordic

Overview:
Iterative fp64 arctangent unit: given a point (x, y), it computes atan2(y, x), i.e. the FPATAN angle result. It is the inverse-direction partner of the combinational sin/cos evaluator. The sin/cos evaluator maps an angle to a coordinate pair; this block maps a coordinate pair back to an angle using CORDIC vectoring, one micro-rotation per clock. It sits in the FPU beside the transcendental units and is driven by the FPU microsequencer with a start/done handshake.

Parameters:
ITERS, 60, number of CORDIC iterations (legal 40..62); sets precision and latency.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
start  input  1  one-cycle request; sampled only when busy=0
y_in  input  64  fp64 ordinate (ST1 for FPATAN)
x_in  input  64  fp64 abscissa (ST0)
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; result/flags valid in the same cycle and held until the next accepted start
result  output  64  fp64 angle in [-pi, +pi]
invalid  output  1  invalid-operation flag for the last operation
inexact  output  1  precision flag for the last operation

Behaviour:
- Reset (async assert, any state, including mid-operation): state=IDLE; busy=0, done=0, result=0, invalid=0, inexact=0. The operation in flight is discarded.
- FSM: IDLE -> PREP -> ITER -> NORM -> DONE -> IDLE. The special-case path is PREP -> DONE.
- IDLE:
  - start=1 latches x_in and y_in and moves to PREP.
  - start while busy=1 is ignored; no latch, no effect.
- PREP (1 cycle): classify the operands; on a special case, load the special result and go to DONE. Otherwise:
  - Decode each operand. Denormals use exponent 1 with no hidden bit.
  - Emax = larger biased exponent. Each 53-bit significand goes into a 64-bit signed fixed-point value with the Emax operand's hidden bit at bit 60.
  - The other operand is right-shifted by the exponent difference; a shift of 62 or more gives 0 (truncated).
  - Apply the operand signs.
  - If x<0: negate x and y, and set z = +pi if y>=0, else z = -pi. Otherwise z = 0.
  - The angle z is a signed Q3.59 value in a 64-bit register.
- ITER (ITERS cycles, i = 0..ITERS-1):
  - d = +1 if y<0, else -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(2^-i).
  - Shifts are arithmetic. atan(2^-i) comes from a 62-entry Q3.59 constant ROM.
- NORM (1 cycle): convert z to fp64.
  - Take sign and magnitude; p = index of the leading one.
  - exponent = 1023 + p - 59.
  - Fraction = the 52 bits below the leading one; bits below those are dropped per the Optional Feature.
  - z == 0 produces +0.
  - inexact=1, invalid=0.
- DONE: done=1 for exactly one cycle, busy drops to 0, then IDLE.
- Latency:
  - Finite, non-special operands: done is asserted ITERS+3 cycles after the start-sample edge.
  - Special cases: done is asserted 2 cycles after the start-sample edge.
- Back-to-back: start is accepted in the same cycle done is high, since busy=0 in DONE.
- Special cases (sy = sign of y); inexact=1 unless stated:
  - Either operand NaN: result = quieted y if y is NaN, otherwise quieted x. Quieting sets frac bit 51. invalid=1 if the selected NaN was signalling; inexact=0.
  - y=±0:
    - x = +0 or positive (incl. +inf): result = y exactly (signed zero); inexact=0.
    - x = -0 or negative (incl. -inf): result = sy ? -pi : +pi.
  - y nonzero finite, x=±0: result = ±pi/2 with sign sy.
  - y=±inf:
    - x finite: ±pi/2.
    - x=+inf: ±pi/4.
    - x=-inf: ±3pi/4.
  - y finite nonzero:
    - x=+inf: ±0, inexact=0.
    - x=-inf: ±pi.
  - Constants: pi 400921FB54442D18; pi/2 3FF921FB54442D18; pi/4 3FE921FB54442D18; 3pi/4 4002D97C7F3321D2. Negative forms set bit 63.
- Accuracy: with ITERS=60, finite results are within 4 ulp of correctly rounded.

Optional Feature:
FP_ATAN2_RNE_EN
- Defined: NORM rounds to nearest-even using guard and sticky bits taken from the dropped z bits. Mantissa carry-out increments the exponent. NORM remains one cycle.
- Undefined: the dropped bits are truncated (round toward zero). Latency is identical in both builds.

Test Plan:
- y=3FF0000000000000 (1.0), x=3FF0000000000000 (1.0), start at cycle T -> done at T+63 (ITERS=60); result within 4 ulp of 3FE921FB54442D18; inexact=1, invalid=0.
- y=BFF0000000000000 (-1.0), x=BFF0000000000000 (-1.0) -> result within 4 ulp of C002D97C7F3321D2.
- y=0000000000000000 (+0), x=BFF0000000000000 (-1.0) -> done at T+2; result=400921FB54442D18. Repeat with y=8000000000000000 (-0), x=+1.0 -> result=8000000000000000, inexact=0.
- y=7FF0000000000001 (SNaN), x=1.0 -> result=7FF8000000000001, invalid=1, done at T+2. Repeat with y=7FF0000000000000 (+inf), x=FFF0000000000000 (-inf) -> result=4002D97C7F3321D2.
- Start an operation, assert rst at T+20 -> busy, done, result and flags are 0 immediately. A new start after release completes normally with the correct result.
- Pulse start again at T+5 with different operands while busy -> ignored; done fires once at T+63 with the first operation's result. A start issued during the done cycle is accepted.
